fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage with IF/ID pipeline register, sitting directly upstream of the control unit.
- Holds the PC and issues word requests to instruction memory through a ready handshake.
- Captures each returned instruction into the IF/ID register and slices it into the decode fields (opcode, funct, rs, rt, rd, shamt, imm, jaddr) that the control unit and register file consume.
- Supports hazard stall and branch/jump redirect with flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INC, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard stall: hold IF/ID contents and PC
- redirect  in  1  branch/jump taken: load redirect_pc, flush
- redirect_pc  in  32  target byte address
- imem_req  out  1  fetch request valid
- imem_addr  out  32  word-aligned fetch address (= pc)
- imem_rdata  in  32  instruction word, valid when imem_ready=1
- imem_ready  in  1  response for the current imem_addr is present this cycle
- if_valid  out  1  IF/ID holds a real instruction
- if_pc  out  32  address of the IF/ID instruction
- if_instr  out  32  IF/ID instruction word
- opcode  out  6  if_instr[31:26]
- rs  out  5  if_instr[25:21]
- rt  out  5  if_instr[20:16]
- rd  out  5  if_instr[15:11]
- shamt  out  5  if_instr[10:6]
- funct  out  6  if_instr[5:0]
- imm  out  16  if_instr[15:0]
- jaddr  out  26  if_instr[25:0]

Behaviour:
- Clocking and reset: one clock domain; reset is synchronous and active-high (clk, rst).
- Reset values:
  - pc = RESET_PC; state = REQ.
  - if_valid = 0; if_pc = 0; if_instr = 0, so all decode fields are 0.
  - Hold buffer is empty.
- Memory contract:
  - imem_ready qualifies imem_rdata for the address driven in the same cycle.
  - A request may be abandoned by changing the address or dropping imem_req; no response is owed.
  - imem_req = 1 iff state == REQ; imem_addr = {pc[31:2], 2'b00}.
- Decode fields: pure combinational slices of the if_instr register.
- State REQ:
  - imem_ready=1, stall=0: IF/ID <= {1, pc, imem_rdata}; pc <= pc+PC_INC; stay REQ. Back-to-back throughput is 1 instruction per cycle with zero-wait memory.
  - imem_ready=1, stall=1: buffer <= {pc, imem_rdata}; pc <= pc+PC_INC; go to HOLD. IF/ID is unchanged.
  - imem_ready=0, stall=0: if_valid <= 0 (bubble; if_instr <= 0).
  - imem_ready=0, stall=1: IF/ID unchanged.
- State HOLD:
  - imem_req = 0.
  - stall=1: IF/ID and buffer unchanged.
  - stall=0: IF/ID <= {1, buffer}; go to REQ.
- Fetch latency: instruction visible on if_* the cycle after imem_ready.
- redirect=1 has highest priority in any state, including under stall:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - if_valid <= 0, if_instr <= 0, if_pc <= 0.
  - Buffer discarded; state <= REQ.
  - Any same-cycle imem_ready/imem_rdata is dropped.
- PC wrap: pc+PC_INC is modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- Reset mid-operation: reset dominates redirect and stall; any pending response is dropped.

Test Plan:
- Zero-wait sequential fetch: rst 1 cycle, imem_ready=1, rdata=addr-based words → if_pc = 0,4,8,… on consecutive cycles, if_valid=1 from the second cycle. For rdata=0x012A4020: opcode=0, rs=9, rt=10, rd=8, funct=0x20.
- Wait states: imem_ready low 2 cycles at addr 0x8 → if_valid=0 for 2 cycles, imem_addr held at 0x8, then if_pc=0x8.
- Stall with response: stall=1 while imem_ready=1 at addr 0xC → IF/ID holds the 0x8 instruction, imem_req=0. After stall drops: if_pc=0xC next cycle, then fetch resumes at 0x10.
- Redirect: redirect=1, redirect_pc=0x0000_0403 with stall=1 and imem_ready=1 → next cycle if_valid=0, imem_addr=0x400, buffer dropped, first valid if_pc=0x400.
- Wrap and reset: redirect to 0xFFFF_FFFC → if_pc sequence 0xFFFF_FFFC, 0x0; rst asserted mid-WAIT → next cycle pc=RESET_PC, if_valid=0, all decode fields 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, ready-handshake instruction memory port,
// IF/ID pipeline register with decode-field slicing, stall hold buffer and redirect flush.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_INC   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [25:0] jaddr
);

    typedef enum logic {
        S_REQ,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] bufpc_q, bufpc_d;
    logic [31:0] bufinstr_q, bufinstr_d;
    logic [31:0] pc_next;

    assign pc_next = pc_q + 32'(PC_INC);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        ifpc_d     = ifpc_q;
        instr_d    = instr_q;
        bufpc_d    = bufpc_q;
        bufinstr_d = bufinstr_q;

        if (redirect) begin
            // Flush wins over stall; any response arriving this cycle is dropped.
            pc_d    = {redirect_pc[31:2], 2'b00};
            valid_d = 1'b0;
            ifpc_d  = '0;
            instr_d = '0;
            state_d = S_REQ;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imem_ready) begin
                        pc_d = pc_next;
                        if (stall) begin
                            bufpc_d    = pc_q;
                            bufinstr_d = imem_rdata;
                            state_d    = S_HOLD;
                        end else begin
                            valid_d = 1'b1;
                            ifpc_d  = pc_q;
                            instr_d = imem_rdata;
                        end
                    end else if (!stall) begin
                        valid_d = 1'b0;
                        instr_d = '0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        valid_d = 1'b1;
                        ifpc_d  = bufpc_q;
                        instr_d = bufinstr_q;
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            ifpc_q     <= '0;
            instr_q    <= '0;
            bufpc_q    <= '0;
            bufinstr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            ifpc_q     <= ifpc_d;
            instr_q    <= instr_d;
            bufpc_q    <= bufpc_d;
            bufinstr_q <= bufinstr_d;
        end
    end

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = {pc_q[31:2], 2'b00};

    assign if_valid = valid_q;
    assign if_pc    = ifpc_q;
    assign if_instr = instr_q;

    assign opcode = instr_q[31:26];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];
    assign shamt  = instr_q[10:6];
    assign funct  = instr_q[5:0];
    assign imm    = instr_q[15:0];
    assign jaddr  = instr_q[25:0];

endmodule
